// File: rtl/ram_wr_pkg.sv
// Shared widths and FSM encoding for the capture-to-RAM writer.
// Imported by ram_wr and trig_detect.
package ram_wr_pkg;

    localparam int SAMPLE_W = 12;
    localparam int ADDR_W   = 10;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_HOLD    = 2'd3
    } state_t;

endpackage

// File: rtl/trig_detect.sv
// Edge-crossing trigger comparator: purely combinational, unsigned compare.
// No hit is possible until a previous sample has been stored.
module trig_detect
    import ram_wr_pkg::*;
(
    input  logic                prev_vld,
    input  logic [SAMPLE_W-1:0] prev,
    input  logic [SAMPLE_W-1:0] cur,
    input  logic [SAMPLE_W-1:0] level,
    input  logic                trig_edge,
    output logic                hit
);

    logic rise_hit;
    logic fall_hit;

    assign rise_hit = (prev < level) && (cur >= level);
    assign fall_hit = (prev > level) && (cur <= level);
    assign hit      = prev_vld && (trig_edge ? fall_hit : rise_hit);

endmodule

// File: rtl/ram_wr.sv
// Triggered waveform capture: writes DEPTH samples into RAM starting at address 0,
// one registered write per accepted sample, then holds until the display's frame_end.
module ram_wr
    import ram_wr_pkg::*;
#(
    parameter int DEPTH        = 1024,
    parameter int AUTO_TIMEOUT = 65535
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cap_en,
    input  logic                auto_trig,
    input  logic                trig_edge,
    input  logic [SAMPLE_W-1:0] trig_level,
    input  logic [SAMPLE_W-1:0] sample_data,
    input  logic                sample_valid,
    input  logic                frame_end,
    output logic                ram_wr_en,
    output logic [ADDR_W-1:0]   ram_wr_addr,
    output logic [SAMPLE_W-1:0] ram_wr_data,
    output logic                busy,
    output logic                capture_done
);

    localparam int                CNT_W    = (AUTO_TIMEOUT < 1) ? 1 : $clog2(AUTO_TIMEOUT + 1);
    localparam logic [CNT_W-1:0]  TMO_MAX  = CNT_W'(AUTO_TIMEOUT);
    localparam logic [ADDR_W-1:0] LAST_ADR = ADDR_W'(DEPTH - 1);

    state_t              state;
    state_t              state_nxt;
    logic [ADDR_W-1:0]   wr_ptr;
    logic [ADDR_W-1:0]   cur_addr;
    logic [SAMPLE_W-1:0] prev;
    logic                prev_vld;
    logic [CNT_W-1:0]    tmo_cnt;
    logic                hit;
    logic                take;
    logic                arm_clr;
    logic                last;

    trig_detect u_trig (
        .prev_vld  (prev_vld),
        .prev      (prev),
        .cur       (sample_data),
        .level     (trig_level),
        .trig_edge (trig_edge),
        .hit       (hit)
    );

    // The triggering sample always lands at address 0; later samples follow wr_ptr.
    assign cur_addr = (state == ST_ARMED) ? '0 : wr_ptr;
    assign last     = (cur_addr == LAST_ADR);
    assign busy     = (state == ST_ARMED) || (state == ST_CAPTURE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        take      = 1'b0;
        arm_clr   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (cap_en) begin
                    state_nxt = ST_ARMED;
                    arm_clr   = 1'b1;
                end
            end
            ST_ARMED: begin
                if (!cap_en) begin
                    state_nxt = ST_IDLE;
                end else if (sample_valid && (hit || (auto_trig && tmo_cnt == TMO_MAX))) begin
                    take      = 1'b1;
                    state_nxt = last ? ST_HOLD : ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                if (sample_valid) begin
                    take = 1'b1;
                    if (last) begin
                        state_nxt = ST_HOLD;
                    end
                end
            end
            ST_HOLD: begin
                // capture_done high means the final write is on the bus this cycle;
                // a frame_end then belongs to the frame that is still being drawn.
                if (frame_end && !capture_done) begin
                    state_nxt = cap_en ? ST_ARMED : ST_IDLE;
                    arm_clr   = cap_en;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ram_wr_en    <= 1'b0;
            ram_wr_addr  <= '0;
            ram_wr_data  <= '0;
            capture_done <= 1'b0;
            wr_ptr       <= '0;
            prev         <= '0;
            prev_vld     <= 1'b0;
            tmo_cnt      <= '0;
        end else begin
            ram_wr_en    <= take;
            capture_done <= take && last;
            if (take) begin
                ram_wr_addr <= cur_addr;
                ram_wr_data <= sample_data;
                wr_ptr      <= cur_addr + 1'b1;
            end
            if (arm_clr) begin
                prev_vld <= 1'b0;
                tmo_cnt  <= '0;
            end else if (state == ST_ARMED && sample_valid) begin
                prev     <= sample_data;
                prev_vld <= 1'b1;
                if (tmo_cnt != TMO_MAX) begin
                    tmo_cnt <= tmo_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: doc/ram_wr.md
RAM_WR -- requirements
Module: ram_wr

Interface
REQ-001 SHALL have parameter DEPTH, default 1024, giving samples written per capture (address range 0..DEPTH-1).
REQ-002 SHALL have parameter AUTO_TIMEOUT, default 65535, giving the number of valid samples waited in ARMED before a forced trigger.
REQ-003 SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-004 SHALL have port rst, input, 1, reset, synchronous and active-high.
REQ-005 SHALL have port cap_en, input, 1, capture enable level.
REQ-006 SHALL have port auto_trig, input, 1, forced-trigger enable.
REQ-007 SHALL have port trig_edge, input, 1, trigger edge select: 0 rising, 1 falling.
REQ-008 SHALL have port trig_level, input, 12, trigger threshold, unsigned.
REQ-009 SHALL have port sample_data, input, 12, waveform sample, unsigned.
REQ-010 SHALL have port sample_valid, input, 1, qualifies sample_data for one cycle.
REQ-011 SHALL have port frame_end, input, 1, one-cycle pulse from the display side at end of the visible frame.
REQ-012 SHALL have port ram_wr_en, output, 1, RAM write strobe.
REQ-013 SHALL have port ram_wr_addr, output, 10, RAM write address.
REQ-014 SHALL have port ram_wr_data, output, 12, RAM write data.
REQ-015 SHALL have port busy, output, 1, high in ARMED or CAPTURE.
REQ-016 SHALL have port capture_done, output, 1, one-cycle pulse after the last write.

Function
REQ-017 SHALL implement FSM IDLE, ARMED, CAPTURE, HOLD.
REQ-018 IDLE -> ARMED when cap_en=1; ARMED -> IDLE when cap_en=0; CAPTURE ignores cap_en and always completes.
REQ-019 In ARMED, on each sample_valid, prev sample SHALL be stored; the stored value is invalid on first entry to ARMED.
REQ-020 Rising trigger: prev < trig_level and current >= trig_level. Falling trigger: prev > trig_level and current <= trig_level. Comparison is 12-bit unsigned.
REQ-021 The triggering sample SHALL be written at address 0, and the FSM enters CAPTURE.
REQ-022 The timeout counter SHALL count valid samples in ARMED and clear on entering ARMED. When it reaches AUTO_TIMEOUT with auto_trig=1, the current valid sample SHALL be treated as a trigger. With auto_trig=0, the counter saturates.
REQ-023 In CAPTURE, each sample_valid SHALL produce exactly one write at the next sequential address; cycles without sample_valid write nothing.
REQ-024 Write latency: ram_wr_en, ram_wr_addr and ram_wr_data are registered and asserted exactly one cycle after the accepted sample_valid.
REQ-025 After the write at address DEPTH-1, the FSM SHALL go to HOLD. capture_done SHALL pulse in the same cycle that write is presented.
REQ-026 HOLD -> ARMED (cap_en=1) or IDLE (cap_en=0) on frame_end. A frame_end outside HOLD, including one coincident with the final write, SHALL be ignored.
REQ-027 The address SHALL never wrap mid-capture. ram_wr_addr holds its last value when ram_wr_en=0.
REQ-028 The triggering sample and the auto-trigger sample SHALL be the same sample: no extra latency is added by the trigger path.

Reset
REQ-029 When rst=1: state IDLE; ram_wr_en=0, ram_wr_addr=0, ram_wr_data=0, busy=0, capture_done=0; timeout counter=0; prev invalid.
REQ-030 rst asserted mid-CAPTURE SHALL abort the capture with no further writes. Partial RAM contents are not cleared.

Structure
REQ-031 The shared package SHALL hold the FSM state encoding, the 12-bit sample width and the 10-bit address width.
REQ-032 The trigger comparator (prev/current/level/edge -> hit) SHALL be one combinational sub-module, trig_detect.

Verification
REQ-033 Ramp 0..4095, level=2048, rising, cap_en=1 -> first write addr 0 data 2048; 1024 writes; capture_done in the cycle of the addr 1023 write.
REQ-034 Ramp down, level=1000, trig_edge=1 -> addr 0 data is the first sample <=1000 preceded by a sample >1000.
REQ-035 Constant 100, level=2048, auto_trig=1, AUTO_TIMEOUT=16 -> capture starts on the 17th valid sample; with auto_trig=0 -> no write ever.
REQ-036 sample_valid every 3rd cycle -> ram_wr_en pattern follows one cycle later; addresses contiguous.
REQ-037 frame_end coincident with the addr 1023 write -> stays in HOLD; the next frame_end re-arms; cap_en=0 at that point -> IDLE, busy=0.
REQ-038 rst pulse after addr 500 written -> ram_wr_en=0 next cycle, state IDLE; re-arm restarts at addr 0.
